// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the RV32E register file: round-robin between ALU (A) and LSU (B)
// results, a registered write strobe, and a pending-write scoreboard that stalls hazardous issue.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rs1,
  input  logic [ADDR_WIDTH-1:0] iss_rs2,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  iss_wr,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH:0]   pending_cnt
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  last_grant_b;
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [NREG-1:0]       set_mask;
  logic [NREG-1:0]       clr_mask;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  grant_a;
  logic                  grant_b;
  logic                  hazard;
  logic                  iss_fire;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_take;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_a = a_valid & (~b_valid | last_grant_b);
    grant_b = b_valid & (~a_valid | ~last_grant_b);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    wb_addr = grant_b ? b_addr : a_addr;
    wb_data = grant_b ? b_data : a_data;
    wb_take = (grant_a | grant_b) & (wb_addr != '0);
  end

  always_comb begin
    hazard = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd]));
    iss_ready = ~hazard;
    iss_fire = iss_valid & ~hazard & iss_wr & (iss_rd != '0);
  end

  // Clear lands with the register-file write; a same-edge set of the same index wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_fire) set_mask[iss_rd] = 1'b1;
    if (rf_wen) clr_mask[rf_waddr] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_b <= 1'b1;
      busy         <= '0;
      pending_cnt  <= '0;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
      rf_wen      <= wb_take;
      if (grant_a | grant_b) last_grant_b <= grant_b;
      if (wb_take) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration order, write latency, scoreboard hazards and reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready, iss_wr;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  pending_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_cnt(pending_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd, input logic wr);
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wr = wr;
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 0; iss_wr = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    #12;
    rst = 1'b0;
    step();

    // Reset state and idle issue
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", pending_cnt, 0);
    issue(3, 4, 5, 0);
    #1 chk("idle_iss_ready", iss_ready, 1);
    iss_valid = 0;

    // RAW on r5, resolved by an A writeback
    issue(0, 0, 5, 1);
    #1 chk("iss_rd5_ready", iss_ready, 1);
    step();
    chk("pending_after_rd5", pending_cnt, 1);
    issue(5, 0, 0, 0);
    #1 chk("raw_stall", iss_ready, 0);
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1 chk("a_ready_r5", a_ready, 1);
    chk("b_ready_r5", b_ready, 0);
    step();
    a_valid = 0;
    chk("wen_r5", rf_wen, 1);
    chk("waddr_r5", rf_waddr, 5);
    chk("wdata_r5", rf_wdata, 32'hDEADBEEF);
    #1 chk("raw_still_stall", iss_ready, 0);
    step();
    chk("raw_released", iss_ready, 1);
    chk("pending_cleared", pending_cnt, 0);
    chk("wen_drop", rf_wen, 0);
    iss_valid = 0;

    // Single B transfer so B becomes last grant, then a tie held for four cycles
    b_valid = 1; b_addr = 9; b_data = 32'h0000_0009;
    #1 chk("b_only_ready", b_ready, 1);
    step();
    chk("waddr_b9", rf_waddr, 9);
    a_valid = 1; a_addr = 1; a_data = 32'hAAAA_0001;
    b_valid = 1; b_addr = 2; b_data = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_a_ready_%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_ready_%0d", i), b_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk($sformatf("rr_waddr_%0d", i), rf_waddr, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_wdata_%0d", i), rf_wdata, (i % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
      chk($sformatf("rr_wen_%0d", i), rf_wen, 1);
    end
    a_valid = 0; b_valid = 0;
    step();
    chk("rr_idle_wen", rf_wen, 0);

    // Writeback to x0: granted but never written
    b_valid = 1; b_addr = 0; b_data = 32'h1234;
    #1 chk("x0_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    chk("x0_wen", rf_wen, 0);
    chk("x0_pending", pending_cnt, 0);

    // WAW on r7
    issue(0, 0, 7, 1);
    #1 chk("rd7_first_ready", iss_ready, 1);
    step();
    chk("rd7_pending", pending_cnt, 1);
    #1 chk("waw_stall", iss_ready, 0);
    iss_valid = 0;
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    step();
    a_valid = 0;
    chk("r7_wen", rf_wen, 1);
    step();
    chk("r7_cleared", pending_cnt, 0);

    // Set and clear of r7 on the same edge: set wins
    a_valid = 1; a_addr = 7; a_data = 32'h70;
    step();
    a_valid = 0;
    chk("r7_second_wen", rf_wen, 1);
    issue(0, 0, 7, 1);
    #1 chk("r7_coincide_ready", iss_ready, 1);
    step();
    chk("set_wins_pending", pending_cnt, 1);
    chk("set_wins_stall", iss_ready, 0);
    iss_valid = 0;

    // Busy r3/r4/r6 plus r7, then reset with a write in flight
    issue(0, 0, 3, 1); step();
    issue(0, 0, 4, 1); step();
    issue(0, 0, 6, 1); step();
    iss_valid = 0;
    chk("pending_four", pending_cnt, 4);
    issue(3, 4, 6, 1);
    #1 chk("busy_hazard", iss_ready, 0);
    iss_valid = 0;
    a_valid = 1; a_addr = 3; a_data = 32'h3333;
    step();
    chk("pre_rst_wen", rf_wen, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wen", rf_wen, 0);
    chk("mid_rst_pending", pending_cnt, 0);
    chk("mid_rst_waddr", rf_waddr, 0);
    issue(3, 4, 6, 1);
    #1 chk("mid_rst_no_hazard", iss_ready, 1);
    iss_valid = 0;
    a_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_wen", rf_wen, 0);
    chk("post_rst_pending", pending_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Writeback controller in front of the RV32E register file. The register file has a single write port.
- Arbitrates round-robin between two writeback requesters: port A (EXU/ALU results) and port B (LSU load results).
- Drives a registered write strobe to the register file.
- Keeps a per-register pending-write scoreboard, so the decoder stalls issue on RAW/WAW hazards until the producing write has landed.

Parameters:
- ADDR_WIDTH, 4, register index width (16 regs, RV32E)
- DATA_WIDTH, 32, register data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  decoder presents an instruction for issue
- iss_ready  out  1  issue accepted this cycle (no hazard)
- iss_rs1  in  ADDR_WIDTH  source register 1 index
- iss_rs2  in  ADDR_WIDTH  source register 2 index
- iss_rd  in  ADDR_WIDTH  destination index
- iss_wr  in  1  instruction writes iss_rd
- a_valid  in  1  port A writeback request
- a_ready  out  1  port A request granted
- a_addr  in  ADDR_WIDTH  port A destination
- a_data  in  DATA_WIDTH  port A data
- b_valid  in  1  port B writeback request
- b_ready  out  1  port B request granted
- b_addr  in  ADDR_WIDTH  port B destination
- b_data  in  DATA_WIDTH  port B data
- rf_wen  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_WIDTH  register file write address (registered)
- rf_wdata  out  DATA_WIDTH  register file write data (registered)
- pending_cnt  out  ADDR_WIDTH+1  number of busy scoreboard bits

Behaviour:
- Reset (asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits 0, pending_cnt=0, last_grant=B (so A wins the first tie).
- Reset asserted mid-operation: any in-flight write is dropped and the scoreboard is cleared.

Arbitration (combinational grant):
- Only A valid -> a_ready=1. Only B valid -> b_ready=1.
- Both valid -> grant the port not equal to last_grant.
- last_grant updates on each accepted transfer.
- At most one ready is high per cycle. A request held without grant must stay stable; the arbiter does not check this.

Write stage:
- On an accepted transfer at edge E1: rf_wen=1, rf_waddr=addr, rf_wdata=data during the cycle after E1. The register file writes at edge E2.
- Latency: valid-to-write strobe is 1 cycle.
- No accepted transfer -> rf_wen=0 next cycle; rf_waddr and rf_wdata hold.
- Transfer to index 0: accepted (ready=1), but rf_wen stays 0 and the scoreboard is untouched.

Scoreboard:
- busy[i], one bit per register. Index 0 is never busy.
- Hazard: iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])).
- iss_ready = ~hazard. iss_ready is combinational and valid only while iss_valid=1.
- Issue fire (iss_valid & iss_ready & iss_wr & iss_rd!=0): set busy[iss_rd] at that edge.
- Clear: at the edge ending a cycle with rf_wen=1, clear busy[rf_waddr]. This coincides with the register file write, so reads after the edge see the new value.
- Set and clear of the same index at the same edge: set wins. This cannot occur for a legal flow because WAW stalls, but the rule is still required.
- Writeback to a non-busy index: the write is performed; the clear is a no-op.
- pending_cnt: registered popcount of busy, updated in the same cycle as busy.

No bypass: a consumer waits until the clear edge. The maximum stall is bounded by producer latency + 1 cycle.

Test Plan:
- Reset then idle -> rf_wen=0, pending_cnt=0, iss_ready=1 for rs1=3, rs2=4, rd=5.
- Issue rd=5 (iss_wr=1), then issue rs1=5 -> iss_ready=0. Then a_valid with addr=5, data=0xDEADBEEF -> a_ready=1; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, iss_ready=1 and pending_cnt=0.
- a_valid and b_valid held together for 4 cycles (A addr=1, B addr=2, all fresh) -> grants A,B,A,B; rf_waddr sequence 1,2,1,2, each one cycle after its grant.
- b_valid with addr=0, data=0x1234 -> b_ready=1; rf_wen stays 0; pending_cnt unchanged.
- Issue rd=7 (busy), then second issue with rd=7 -> iss_ready=0 (WAW). Writeback addr=7 coincides with an issue of rd=7 at the same edge -> busy[7] remains 1.
- Set busy on regs 3, 4 and 6, then pulse rst mid-stream with a_valid high -> immediately rf_wen=0, pending_cnt=0, all hazards clear.
